// File: rtl/vm_pkg.sv
// Shared types and helpers for the parametrised vending controller.
package vm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    // Coin acceptor codes
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_10   = 2'b11;

    // Change actuator codes
    localparam logic [1:0] BACK_NONE = 2'b00;
    localparam logic [1:0] BACK_1    = 2'b01;
    localparam logic [1:0] BACK_2    = 2'b10;

    // Value of a coin code in 0.5-yuan units
    function automatic logic [3:0] coin_value(input logic [1:0] code);
        logic [3:0] v;
        case (code)
            COIN_1:  v = 4'd1;
            COIN_2:  v = 4'd2;
            COIN_10: v = 4'd10;
            default: v = 4'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-product stock counters with restock, single-item decrement and
// sold-out flags.
module vm_stock_bank
    import vm_pkg::*;
#(
    parameter int N_ITEMS    = 4,
    parameter int SEL_W      = 3,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restock,
    input  logic               dec_en,
    input  logic [SEL_W-1:0]   dec_item,
    output logic [N_ITEMS-1:0] sold_out
);

    localparam logic [STOCK_W-1:0] INIT_Q = STOCK_W'(INIT_STOCK);

    logic [STOCK_W-1:0] stock [N_ITEMS];

    // Restock wins over a simultaneous decrement; counters never go below zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_ITEMS; k++) stock[k] <= INIT_Q;
        end else begin
            for (int k = 0; k < N_ITEMS; k++) begin
                if (restock)
                    stock[k] <= INIT_Q;
                else if (dec_en && dec_item == SEL_W'(k + 1) && stock[k] != '0)
                    stock[k] <= stock[k] - 1'b1;
            end
        end
    end

    // An item is sold out when its counter is empty
    always_comb begin
        sold_out = '0;
        for (int k = 0; k < N_ITEMS; k++) sold_out[k] = (stock[k] == '0);
    end

endmodule

// File: rtl/vending_machine_param.sv
// Multi-product vending controller: product selection, coin collection,
// vend, cancel/timeout refund and coin-by-coin change, largest coin first.
module vending_machine_param
    import vm_pkg::*;
#(
    parameter int                          N_ITEMS    = 4,
    parameter int                          SEL_W      = 3,
    parameter int                          PRICE_W    = 8,
    parameter logic [N_ITEMS*PRICE_W-1:0]  PRICES     = {8'd4, 8'd3, 8'd2, 8'd1},
    parameter int                          STOCK_W    = 4,
    parameter int                          INIT_STOCK = 15,
    parameter int                          TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   select,
    input  logic [1:0]         coin,
    input  logic               cancel,
    input  logic               restock,
    output logic [SEL_W-1:0]   drink,
    output logic [1:0]         back,
    output logic               busy,
    output logic               err,
    output logic [PRICE_W:0]   credit,
    output logic [N_ITEMS-1:0] sold_out
);

    localparam int CW    = PRICE_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    state_t             state_q, state_d;
    logic [CW-1:0]      credit_q, credit_d;
    logic [SEL_W-1:0]   item_q, item_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [SEL_W-1:0]   drink_d;
    logic [1:0]         back_d;
    logic               busy_d, err_d;

    logic [CW-1:0]      coin_units;
    logic [CW-1:0]      credit_plus;
    logic [CW-1:0]      disp;
    logic [CW-1:0]      price_cur;
    logic               sel_ok;

    // Change coin for a given remaining credit, largest coin first
    function automatic logic [1:0] back_code(input logic [CW-1:0] c);
        logic [1:0] b;
        if (c >= CW'(2))      b = BACK_2;
        else if (c != '0)     b = BACK_1;
        else                  b = BACK_NONE;
        return b;
    endfunction

    vm_stock_bank #(
        .N_ITEMS    (N_ITEMS),
        .SEL_W      (SEL_W),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk      (clk),
        .rst      (rst),
        .restock  (restock),
        .dec_en   (state_q == VEND),
        .dec_item (item_q),
        .sold_out (sold_out)
    );

    // Selection check, latched item price and per-cycle money arithmetic
    always_comb begin
        sel_ok    = 1'b0;
        price_cur = '0;
        for (int k = 0; k < N_ITEMS; k++) begin
            if (select == SEL_W'(k + 1)) sel_ok = !sold_out[k];
            if (item_q == SEL_W'(k + 1)) price_cur = CW'(PRICES[k*PRICE_W +: PRICE_W]);
        end
        coin_units  = CW'(coin_value(coin));
        credit_plus = credit_q + coin_units;
        if (credit_q >= CW'(2))  disp = CW'(2);
        else if (credit_q != '0) disp = CW'(1);
        else                     disp = '0;
    end

    // Next-state, credit/timer update and next registered outputs
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        item_d   = item_q;
        timer_d  = timer_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (coin != COIN_NONE) begin
                    // A coin without a selection is simply handed back
                    credit_d = coin_units;
                    state_d  = CHANGE;
                end else if (select != '0) begin
                    if (sel_ok) begin
                        state_d  = COLLECT;
                        item_d   = select;
                        credit_d = '0;
                        timer_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (cancel) begin
                    credit_d = credit_plus;
                    state_d  = (credit_plus != '0) ? CHANGE : IDLE;
                end else if (credit_plus >= price_cur) begin
                    credit_d = credit_plus - price_cur;
                    state_d  = VEND;
                end else if (coin == COIN_NONE && timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d  = (credit_q != '0) ? CHANGE : IDLE;
                end else begin
                    credit_d = credit_plus;
                    timer_d  = (coin != COIN_NONE) ? '0 : timer_q + 1'b1;
                end
            end
            VEND: begin
                credit_d = credit_plus;
                state_d  = (credit_plus != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                credit_d = credit_q - disp + coin_units;
                state_d  = (credit_d != '0) ? CHANGE : IDLE;
            end
            default: state_d = IDLE;
        endcase
        drink_d = (state_d == VEND) ? item_d : '0;
        back_d  = (state_d == CHANGE) ? back_code(credit_d) : BACK_NONE;
        busy_d  = (state_d != IDLE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            item_q   <= '0;
            timer_q  <= '0;
            drink    <= '0;
            back     <= BACK_NONE;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            item_q   <= item_d;
            timer_q  <= timer_d;
            drink    <= drink_d;
            back     <= back_d;
            busy     <= busy_d;
            err      <= err_d;
        end
    end

    assign credit = credit_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param.
module tb_vending_machine_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] select;
    logic [1:0] coin;
    logic       cancel;
    logic       restock;
    logic [2:0] drink;
    logic [1:0] back;
    logic       busy;
    logic       err;
    logic [8:0] credit;
    logic [3:0] sold_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Prices: item1=2, item2=3, item3=3, item4=4
    vending_machine_param #(
        .N_ITEMS    (4),
        .SEL_W      (3),
        .PRICE_W    (8),
        .PRICES     ({8'd4, 8'd3, 8'd3, 8'd2}),
        .STOCK_W    (4),
        .INIT_STOCK (15),
        .TIMEOUT    (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .select   (select),
        .coin     (coin),
        .cancel   (cancel),
        .restock  (restock),
        .drink    (drink),
        .back     (back),
        .busy     (busy),
        .err      (err),
        .credit   (credit),
        .sold_out (sold_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; select = '0; coin = '0; cancel = 1'b0; restock = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_drink",  32'(drink),    32'd0);
        chk("rst_back",   32'(back),     32'd0);
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_err",    32'(err),      32'd0);
        chk("rst_credit", 32'(credit),   32'd0);
        chk("rst_sold",   32'(sold_out), 32'd0);

        // Item 1, exact payment 1+1
        select = 3'd1; tick(); select = '0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_cred0", 32'(credit), 32'd0);
        coin = 2'b01; tick();
        chk("t1_cred1", 32'(credit), 32'd1);
        chk("t1_nodrink", 32'(drink), 32'd0);
        tick(); coin = 2'b00;
        chk("t1_drink", 32'(drink), 32'd1);
        chk("t1_back", 32'(back), 32'd0);
        tick();
        chk("t1_drink_off", 32'(drink), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_noback", 32'(back), 32'd0);

        // Item 1, pay 1+2, one unit back
        select = 3'd1; tick(); select = '0;
        coin = 2'b01; tick();
        coin = 2'b10; tick(); coin = 2'b00;
        chk("t2_drink", 32'(drink), 32'd1);
        chk("t2_cred", 32'(credit), 32'd1);
        tick();
        chk("t2_back", 32'(back), 32'd1);
        chk("t2_drink_off", 32'(drink), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        tick();
        chk("t2_back_off", 32'(back), 32'd0);
        chk("t2_idle", 32'(busy), 32'd0);

        // Item 4, pay 10, three 2-unit coins back
        select = 3'd4; tick(); select = '0;
        coin = 2'b11; tick(); coin = 2'b00;
        chk("t3_drink", 32'(drink), 32'd4);
        chk("t3_cred", 32'(credit), 32'd6);
        tick();
        chk("t3_back_a", 32'(back), 32'd2);
        tick();
        chk("t3_back_b", 32'(back), 32'd2);
        chk("t3_cred_b", 32'(credit), 32'd4);
        tick();
        chk("t3_back_c", 32'(back), 32'd2);
        tick();
        chk("t3_back_off", 32'(back), 32'd0);
        chk("t3_idle", 32'(busy), 32'd0);

        // Item 3, coin 2 then cancel
        select = 3'd3; tick(); select = '0;
        coin = 2'b10; tick(); coin = 2'b00;
        chk("t4_cred", 32'(credit), 32'd2);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("t4_back", 32'(back), 32'd2);
        chk("t4_nodrink", 32'(drink), 32'd0);
        tick();
        chk("t4_back_off", 32'(back), 32'd0);
        chk("t4_idle", 32'(busy), 32'd0);

        // Item 3, no coins: auto-cancel after exactly 64 cycles
        select = 3'd3; tick(); select = '0;
        for (int i = 0; i < 63; i++) tick();
        chk("t5_still_busy", 32'(busy), 32'd1);
        tick();
        chk("t5_timeout_idle", 32'(busy), 32'd0);
        chk("t5_noback", 32'(back), 32'd0);

        // Coin with no selection is refunded
        coin = 2'b01; tick(); coin = 2'b00;
        chk("t6_back", 32'(back), 32'd1);
        chk("t6_busy", 32'(busy), 32'd1);
        tick();
        chk("t6_idle", 32'(busy), 32'd0);

        // Illegal select code
        select = 3'd6; tick(); select = '0;
        chk("t7_err", 32'(err), 32'd1);
        chk("t7_busy", 32'(busy), 32'd0);
        tick();
        chk("t7_err_off", 32'(err), 32'd0);

        // Sell out item 2
        for (int i = 0; i < 15; i++) begin
            select = 3'd2; tick(); select = '0;
            coin = 2'b10; tick();
            coin = 2'b01; tick(); coin = 2'b00;
            chk("t8_drink", 32'(drink), 32'd2);
            tick();
        end
        chk("t8_sold", 32'(sold_out), 32'b0010);
        select = 3'd2; tick(); select = '0;
        chk("t8_err", 32'(err), 32'd1);
        chk("t8_busy", 32'(busy), 32'd0);
        tick();
        chk("t8_err_off", 32'(err), 32'd0);
        restock = 1'b1; tick(); restock = 1'b0;
        chk("t8_restock", 32'(sold_out), 32'd0);
        select = 3'd2; tick(); select = '0;
        chk("t8_sel_ok", 32'(busy), 32'd1);
        chk("t8_sel_noerr", 32'(err), 32'd0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("t8_cancel_idle", 32'(busy), 32'd0);

        // Reset in COLLECT with credit 3
        select = 3'd4; tick(); select = '0;
        coin = 2'b01; tick();
        coin = 2'b10; tick(); coin = 2'b00;
        chk("t9_cred", 32'(credit), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("t9_cred_rst", 32'(credit), 32'd0);
        chk("t9_busy_rst", 32'(busy), 32'd0);
        chk("t9_back_rst", 32'(back), 32'd0);
        chk("t9_drink_rst", 32'(drink), 32'd0);
        tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t9_noback", 32'(back), 32'd0);
            chk("t9_idle", 32'(busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
